stream_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8-bit valid/ready stream input (sample_module stream_in_valid/ready/data) between NUM_REQ requesters.
- Grants are packet-based: a grant lasts until the last beat, the burst limit, or an idle timeout.
- Sits directly upstream of the sample stream datapath.
- Output is a combinational pass-through of the granted requester. Arbitration state is registered.

---
 rtl/stream_arb_pkg.sv | 36 +++
 rtl/rr_priority_picker.sv | 23 ++
 rtl/stream_arbiter.sv | 124 ++++++++++++
 tb/tb_stream_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types and the round-robin search helper for the stream arbiter.
// Purely declarative: no state, no latency, no flow control.
package stream_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int MAX_REQ = 16;
  localparam int PICK_W  = 4;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } pick_t;

  // Searches ptr+1, ptr+2, ... wrapping at num_req, which need not be a power of 2.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [PICK_W-1:0]  ptr,
                                    input int                 num_req);
    pick_t res;
    int    cand;
    res = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= num_req) cand = cand - num_req;
      if (k <= num_req && !res.found && valid[PICK_W'(cand)]) begin
        res.found = 1'b1;
        res.idx   = PICK_W'(cand);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Rotate-and-priority-encode: first valid requester after ptr, round-robin order.
// Combinational, zero latency; no flow control of its own.
module rr_priority_picker
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [MAX_REQ-1:0] valid_ext;
  pick_t              pick;

  assign valid_ext = MAX_REQ'(valid);
  assign pick      = rr_pick(valid_ext, PICK_W'(ptr), NUM_REQ);
  assign idx       = IDX_W'(pick.idx);
  assign found     = pick.found;

endmodule

// File: rtl/stream_arbiter.sv
// Packet-based round-robin arbiter muxing NUM_REQ valid/ready streams onto one output.
// 1-cycle arbitration then combinational pass-through; out_ready flows back only to the granted requester.
module stream_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 4,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic [$clog2(NUM_REQ)-1:0]    out_src,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int BC_W  = $clog2(MAX_BURST + 1);
  localparam int IC_W  = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [BC_W-1:0]  BURST_LAST = BC_W'(MAX_BURST - 1);
  localparam logic [IC_W-1:0]  IDLE_LAST  = IC_W'(IDLE_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] PTR_RESET  = IDX_W'(NUM_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [BC_W-1:0]  beat_q, beat_d;
  logic [IC_W-1:0]  idle_q, idle_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             granted;
  logic             xfer;
  logic             release_grant;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .valid (req_valid),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign granted = (state_q == GRANT);
  assign busy    = granted;

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_src   = '0;
    req_ready = '0;
    if (granted) begin
      out_valid        = req_valid[sel_q];
      out_data         = req_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
      out_last         = req_last[sel_q];
      out_src          = sel_q;
      req_ready[sel_q] = out_ready;
    end
  end

  assign xfer = out_valid && out_ready;

  // Last beat and burst limit may coincide; either way this is one release.
  assign release_grant = granted &&
                         ((xfer && (out_last || beat_q == BURST_LAST)) ||
                          (!req_valid[sel_q] && idle_q == IDLE_LAST));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    beat_d  = beat_q;
    idle_d  = idle_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          beat_d  = '0;
          idle_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer) beat_d = beat_q + BC_W'(1);
        if (req_valid[sel_q])       idle_d = '0;
        else if (idle_q != IDLE_LAST) idle_d = idle_q + IC_W'(1);
        if (release_grant) begin
          ptr_d   = sel_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RESET;
      sel_q   <= '0;
      beat_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      beat_q  <= beat_d;
      idle_q  <= idle_d;
    end
  end

endmodule

// File: tb/tb_stream_arbiter.sv
// Scoreboard bench for stream_arbiter: per-requester beat queues drive stimulus,
// expected output beats are queued up front and popped on each output handshake.
module tb_stream_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic [1:0]        out_src;
  logic              busy;

  stream_arbiter #(
    .NUM_REQ      (NR),
    .DATA_WIDTH   (DW),
    .MAX_BURST    (4),
    .IDLE_TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_last  (req_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [7:0] dly;
  } beat_t;

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] data;
    logic       last;
  } exp_t;

  beat_t      drvq[NR][$];
  int         wait_cnt[NR];
  exp_t       sbq[$];
  bit         trace[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         stall_from = 0;
  int         stall_len = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic add_beat(input int r, input logic [7:0] d, input logic l, input int dly);
    beat_t b;
    b.data = d;
    b.last = l;
    b.dly  = 8'(dly);
    if (drvq[r].size() == 0) wait_cnt[r] = dly;
    drvq[r].push_back(b);
  endtask

  task automatic expect_beat(input int src, input logic [7:0] d, input logic l);
    exp_t e;
    e.src  = 2'(src);
    e.data = d;
    e.last = l;
    sbq.push_back(e);
  endtask

  task automatic drive();
    for (int r = 0; r < NR; r++) begin
      if (drvq[r].size() != 0 && wait_cnt[r] == 0) begin
        req_valid[r]          = 1'b1;
        req_data[r*DW +: DW]  = drvq[r][0].data;
        req_last[r]           = drvq[r][0].last;
      end else begin
        req_valid[r]          = 1'b0;
        req_data[r*DW +: DW]  = '0;
        req_last[r]           = 1'b0;
      end
      if (wait_cnt[r] > 0) wait_cnt[r]--;
    end
    out_ready = !(stall_len > 0 && cyc >= stall_from && cyc < stall_from + stall_len);
  endtask

  task automatic cycle();
    logic [NR-1:0] hs;
    exp_t          e;
    beat_t         b;
    @(negedge clk);
    trace.push_back(busy);
    if (!busy) check("idle_quiet", 32'({out_valid, out_last, out_src, req_ready, out_data}), 32'd0);
    check("rdy_mask", 32'(req_ready), (busy && out_ready) ? (32'd1 << out_src) : 32'd0);
    if (prev_stall && busy) check("hold_data", 32'(out_data), 32'(prev_data));
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("sb_extra", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("src", 32'(out_src), 32'(e.src));
        check("data", 32'(out_data), 32'(e.data));
        check("last", 32'(out_last), 32'(e.last));
      end
    end
    prev_stall = busy && out_valid && !out_ready;
    prev_data  = out_data;
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int r = 0; r < NR; r++) begin
      if (hs[r] && drvq[r].size() != 0) begin
        b = drvq[r].pop_front();
        wait_cnt[r] = (drvq[r].size() != 0) ? int'(drvq[r][0].dly) : 0;
      end
    end
    cyc++;
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic trace_check(input string tag, input int n, input logic [31:0] exp);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n && i < trace.size(); i++) v = {v[30:0], trace[i]};
    check(tag, v, exp);
  endtask

  task automatic clear_queues();
    for (int r = 0; r < NR; r++) begin
      drvq[r].delete();
      wait_cnt[r] = 0;
    end
    sbq.delete();
    trace.delete();
  endtask

  // Holds all requests high through reset to show the outputs stay quiet.
  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '1;
    req_data  = '1;
    req_last  = '1;
    out_ready = 1'b1;
    clear_queues();
    @(posedge clk);
    @(negedge clk);
    check("rst_outs", 32'({out_valid, out_last, out_src, req_ready, out_data, busy}), 32'd0);
    @(posedge clk);
    #1;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    rst        = 1'b0;
    cyc        = 0;
    stall_len  = 0;
    prev_stall = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    out_ready = 1'b0;

    // Single 3-beat packet from requester 0.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      add_beat(0, 8'(8'h51 + k), k == 2, 0);
      expect_beat(0, 8'(8'h51 + k), k == 2);
    end
    drive();
    run(8);
    trace_check("busy_single", 6, 32'b011100);
    check("drain_single", sbq.size(), 0);

    // All four requesters continuously valid with 1-beat packets.
    do_reset();
    for (int g = 0; g < 4; g++)
      for (int r = 0; r < NR; r++) begin
        add_beat(r, 8'(r*16 + g), 1'b1, 0);
        expect_beat(r, 8'(r*16 + g), 1'b1);
      end
    drive();
    run(40);
    check("drain_rr", sbq.size(), 0);

    // 10-beat packet split by the burst limit into 4, 4, 2.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      add_beat(2, 8'(8'hA0 + k), k == 9, 0);
      expect_beat(2, 8'(8'hA0 + k), k == 9);
    end
    drive();
    run(20);
    trace_check("busy_burst", 14, 32'b01111011110110);
    check("drain_burst", sbq.size(), 0);

    // Requester 1 goes quiet after one beat; timeout hands over to requester 3.
    do_reset();
    add_beat(1, 8'h10, 1'b0, 0);
    add_beat(1, 8'h11, 1'b0, 20);
    add_beat(1, 8'h12, 1'b1, 0);
    add_beat(3, 8'h30, 1'b0, 0);
    add_beat(3, 8'h31, 1'b1, 0);
    expect_beat(1, 8'h10, 1'b0);
    expect_beat(3, 8'h30, 1'b0);
    expect_beat(3, 8'h31, 1'b1);
    expect_beat(1, 8'h11, 1'b0);
    expect_beat(1, 8'h12, 1'b1);
    drive();
    run(30);
    trace_check("busy_timeout", 14, 32'b01111111110110);
    check("drain_timeout", sbq.size(), 0);

    // out_ready held low for 5 cycles mid-packet; last coincides with burst limit.
    do_reset();
    stall_from = 2;
    stall_len  = 5;
    for (int k = 0; k < 4; k++) begin
      add_beat(0, 8'(8'hC0 + k), k == 3, 0);
      expect_beat(0, 8'(8'hC0 + k), k == 3);
    end
    drive();
    run(14);
    trace_check("busy_stall", 11, 32'b01111111110);
    check("drain_stall", sbq.size(), 0);

    // Asynchronous reset in the middle of requester 1's grant.
    do_reset();
    add_beat(0, 8'h60, 1'b1, 0);
    for (int k = 0; k < 6; k++) add_beat(1, 8'(8'h70 + k), 1'b0, 0);
    expect_beat(0, 8'h60, 1'b1);
    expect_beat(1, 8'h70, 1'b0);
    expect_beat(1, 8'h71, 1'b0);
    drive();
    run(5);
    check("sb_pre_rst", sbq.size(), 0);
    check("busy_pre_rst", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 32'({out_valid, req_ready, busy}), 32'd0);
    clear_queues();
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    cyc        = 0;
    prev_stall = 1'b0;
    add_beat(0, 8'h80, 1'b1, 0);
    add_beat(1, 8'h90, 1'b1, 0);
    expect_beat(0, 8'h80, 1'b1);
    expect_beat(1, 8'h90, 1'b1);
    drive();
    run(6);
    check("drain_post_rst", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
